// File: rtl/button_cmd_pkg.sv
// Shared command codes, debounce state encoding and default timing for the
// four-button command front end.
package button_cmd_pkg;

   localparam logic [7:0] CMD_MUTE = 8'h00;
   localparam logic [7:0] CMD_PLAY = 8'h01;
   localparam logic [7:0] CMD_SKIP = 8'h02;
   localparam logic [7:0] CMD_STOP = 8'h03;
   localparam logic [7:0] CMD_IDLE = 8'hFF;

   // 20 ms of stable samples at 50 MHz
   localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

   typedef enum logic [2:0] {
      ARM_WAIT     = 3'd0,
      IDLE         = 3'd1,
      PRESS_WAIT   = 3'd2,
      HELD         = 3'd3,
      RELEASE_WAIT = 3'd4
   } deb_state_t;

   function automatic logic [7:0] cmd_code(input logic [1:0] idx);
      logic [7:0] code;
      case (idx)
         2'd0:    code = CMD_MUTE;
         2'd1:    code = CMD_PLAY;
         2'd2:    code = CMD_SKIP;
         2'd3:    code = CMD_STOP;
         default: code = CMD_IDLE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/debounce_key.sv
// One button: 2-flop synchronizer into a debounce FSM that reports the
// debounced level and a single-cycle press event.
module debounce_key
   import button_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
)
(
   input  logic clock,
   input  logic reset_n,
   input  logic key_n,
   output logic level,
   output logic press_pulse
);

   localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          pressed_s;
   deb_state_t    state_r;
   deb_state_t    state_s;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_s;
   logic          pulse_s;
   logic          level_s;
   logic          level_r;

   // Synchronizer flops idle at 1 so reset looks like a released key.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= key_n;
         sync2_r <= sync1_r;
      end
   end

   assign pressed_s = ~sync2_r;

   // State, counter and debounced level registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ARM_WAIT;
         count_r <= CNT_ZERO;
         level_r <= 1'b0;
      end else begin
         state_r <= state_s;
         count_r <= count_s;
         level_r <= level_s;
      end
   end

   // Next-state logic; the press event fires on the transition into HELD.
   always_comb begin
      state_s = state_r;
      count_s = count_r;
      pulse_s = 1'b0;
      case (state_r)
         ARM_WAIT: begin
            if (pressed_s) begin
               count_s = CNT_ZERO;
            end else if (count_r == CNT_LAST) begin
               state_s = IDLE;
               count_s = CNT_ZERO;
            end else begin
               count_s = count_r + CNT_ONE;
            end
         end
         IDLE: begin
            if (pressed_s) begin
               state_s = PRESS_WAIT;
               count_s = CNT_ZERO;
            end else begin
               count_s = CNT_ZERO;
            end
         end
         PRESS_WAIT: begin
            if (!pressed_s) begin
               state_s = IDLE;
               count_s = CNT_ZERO;
            end else if (count_r == CNT_LAST) begin
               state_s = HELD;
               count_s = CNT_ZERO;
               pulse_s = 1'b1;
            end else begin
               count_s = count_r + CNT_ONE;
            end
         end
         HELD: begin
            if (!pressed_s) begin
               state_s = RELEASE_WAIT;
               count_s = CNT_ZERO;
            end else begin
               count_s = CNT_ZERO;
            end
         end
         RELEASE_WAIT: begin
            if (pressed_s) begin
               state_s = HELD;
               count_s = CNT_ZERO;
            end else if (count_r == CNT_LAST) begin
               state_s = IDLE;
               count_s = CNT_ZERO;
            end else begin
               count_s = count_r + CNT_ONE;
            end
         end
         default: begin
            state_s = ARM_WAIT;
            count_s = CNT_ZERO;
         end
      endcase
   end

   assign level_s     = (state_s == HELD) || (state_s == RELEASE_WAIT);
   assign level       = level_r;
   assign press_pulse = pulse_s;

endmodule

// File: rtl/button_cmd.sv
// Four debounced buttons feeding a pending register and a fixed-priority
// arbiter that issues one registered command code per cycle.
module button_cmd
   import button_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
)
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] key_n,
   output logic [7:0] bot,
   output logic [3:0] key_level,
   output logic       overrun
);

   logic [3:0] press_s;
   logic [3:0] level_s;
   logic [3:0] pending_r;
   logic [3:0] pending_s;
   logic [3:0] grant_s;
   logic [7:0] grant_code_s;
   logic [7:0] bot_r;
   logic       overrun_r;

   debounce_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
      .clock(clock), .reset_n(reset_n), .key_n(key_n[0]),
      .level(level_s[0]), .press_pulse(press_s[0])
   );
   debounce_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
      .clock(clock), .reset_n(reset_n), .key_n(key_n[1]),
      .level(level_s[1]), .press_pulse(press_s[1])
   );
   debounce_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key2 (
      .clock(clock), .reset_n(reset_n), .key_n(key_n[2]),
      .level(level_s[2]), .press_pulse(press_s[2])
   );
   debounce_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key3 (
      .clock(clock), .reset_n(reset_n), .key_n(key_n[3]),
      .level(level_s[3]), .press_pulse(press_s[3])
   );

   // Lowest-index pending button wins the single issue slot.
   always_comb begin
      grant_s      = 4'b0000;
      grant_code_s = CMD_IDLE;
      if (pending_r[0]) begin
         grant_s      = 4'b0001;
         grant_code_s = cmd_code(2'd0);
      end else if (pending_r[1]) begin
         grant_s      = 4'b0010;
         grant_code_s = cmd_code(2'd1);
      end else if (pending_r[2]) begin
         grant_s      = 4'b0100;
         grant_code_s = cmd_code(2'd2);
      end else if (pending_r[3]) begin
         grant_s      = 4'b1000;
         grant_code_s = cmd_code(2'd3);
      end else begin
         grant_s      = 4'b0000;
         grant_code_s = CMD_IDLE;
      end
   end

   // A new press on the button being issued re-arms its pending bit.
   assign pending_s = (pending_r & ~grant_s) | press_s;

   // Pending, command and sticky overrun registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending_r <= 4'b0000;
         bot_r     <= CMD_IDLE;
         overrun_r <= 1'b0;
      end else begin
         pending_r <= pending_s;
         bot_r     <= grant_code_s;
         overrun_r <= overrun_r | (|(press_s & pending_r));
      end
   end

   assign bot       = bot_r;
   assign key_level = level_s;
   assign overrun   = overrun_r;

endmodule
